// File: rtl/stream_top_pkg.sv
// stream_top_pkg: shared widths, beat types and lane-wise adder for stream_top.
package stream_top_pkg;
  localparam int DATA_WIDTH = 512;
  localparam int LANE_WIDTH = 32;
  localparam int N_LANES = DATA_WIDTH / LANE_WIDTH;
  localparam int SID_WIDTH = 1;
  localparam int N_STREAMS = 2 ** SID_WIDTH;
  typedef logic [LANE_WIDTH-1:0] lane_t;
  typedef lane_t [N_LANES-1:0] beat_t;
  function automatic beat_t lane_add(beat_t a, beat_t b);
    beat_t r;
    for (int k = 0; k < N_LANES; k++) r[k] = a[k] + b[k];
    return r;
  endfunction
endpackage

// File: rtl/stream_accum.sv
// stream_accum: one stream's lane-wise running sum and beat counter.
module stream_accum
  import stream_top_pkg::*;
#(
  parameter int N_CYCLES = 4
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  i_valid,
  input  beat_t i_data,
  output logic  o_final,
  output beat_t o_sum
);
  localparam int CW = $clog2(N_CYCLES + 1);
  beat_t r_acc;
  logic [CW-1:0] r_cnt;
  assign o_final = i_valid && r_cnt == CW'(N_CYCLES - 1);
  assign o_sum = lane_add(r_acc, i_data);
  always_ff @(posedge clk or posedge rst_n)
    if (rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_valid) begin
      r_acc <= o_final ? '0 : o_sum;
      r_cnt <= o_final ? '0 : r_cnt + 1'b1;
    end
endmodule

// File: rtl/stream_top.sv
// stream_top: folds N_CYCLES-beat bursts per stream into a registered lane-wise sum.
module stream_top
  import stream_top_pkg::*;
#(
  parameter int N_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [SID_WIDTH-1:0]  sid_in,
  input  logic                  data_valid,
  output logic [DATA_WIDTH-1:0] data_out
);
  logic  w_final [N_STREAMS];
  beat_t w_sum [N_STREAMS];
  beat_t w_next;
  beat_t r_out;
  for (genvar s = 0; s < N_STREAMS; s++) begin : g_acc
    stream_accum #(.N_CYCLES(N_CYCLES)) u_acc (
      .clk(clk),
      .rst_n(rst_n),
      .i_valid(data_valid && sid_in == SID_WIDTH'(s)),
      .i_data(data_in),
      .o_final(w_final[s]),
      .o_sum(w_sum[s])
    );
  end
  // only the addressed stream can complete in a given cycle
  always_comb begin
    w_next = r_out;
    for (int s = 0; s < N_STREAMS; s++) w_next = w_final[s] ? w_sum[s] : w_next;
  end
  always_ff @(posedge clk or posedge rst_n)
    if (rst_n) r_out <= '0;
    else r_out <= w_next;
  assign data_out = r_out;
endmodule

// File: tb/tb_stream_top.sv
// tb_stream_top: directed bursts against a per-stream beat-summing model plus literal checks.
module tb_stream_top;
  import stream_top_pkg::*;
  localparam int N_CYCLES = 4;
  logic clk = 0;
  logic rst_n = 0;
  logic [DATA_WIDTH-1:0] data_in = '0;
  logic [SID_WIDTH-1:0] sid_in = '0;
  logic data_valid = 0;
  logic [DATA_WIDTH-1:0] data_out;
  int n_checks = 0;
  int n_fails = 0;
  logic [31:0] m_sum [N_STREAMS][N_LANES];
  int m_cnt [N_STREAMS];
  logic [DATA_WIDTH-1:0] m_exp = '0;

  stream_top #(.N_CYCLES(N_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .sid_in(sid_in),
    .data_valid(data_valid), .data_out(data_out)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_WIDTH-1:0] fill(logic [31:0] v);
    logic [DATA_WIDTH-1:0] b;
    for (int k = 0; k < N_LANES; k++) b[k*32 +: 32] = v;
    return b;
  endfunction

  task automatic check(string name, logic [DATA_WIDTH-1:0] act, logic [DATA_WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      m_exp = '0;
      for (int s = 0; s < N_STREAMS; s++) begin
        m_cnt[s] = 0;
        for (int k = 0; k < N_LANES; k++) m_sum[s][k] = '0;
      end
    end else if (data_valid) begin
      for (int k = 0; k < N_LANES; k++) m_sum[sid_in][k] = m_sum[sid_in][k] + data_in[k*32 +: 32];
      m_cnt[sid_in]++;
      if (m_cnt[sid_in] == N_CYCLES) begin
        for (int k = 0; k < N_LANES; k++) begin
          m_exp[k*32 +: 32] = m_sum[sid_in][k];
          m_sum[sid_in][k] = '0;
        end
        m_cnt[sid_in] = 0;
      end
    end
  end

  always @(negedge clk) check("cycle", data_out, m_exp);

  task automatic drive(logic v, logic [SID_WIDTH-1:0] s, logic [DATA_WIDTH-1:0] d);
    @(posedge clk);
    #1;
    data_valid = v;
    sid_in = s;
    data_in = d;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(0, '0, {16{$urandom}});
  endtask

  logic [DATA_WIDTH-1:0] b;
  initial begin
    #1 rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      data_valid = 1;
      sid_in = SID_WIDTH'($urandom);
      data_in = {16{$urandom}};
      @(negedge clk);
      check("reset_out", data_out, '0);
    end
    @(posedge clk);
    #1 rst_n = 0;
    data_valid = 0;
    idle(3);
    check("post_reset_idle", data_out, '0);

    for (int i = 0; i < 4; i++) drive(1, 0, fill(1));
    check("basic_before_done", data_out, '0);
    idle(1);
    check("basic_sum", data_out, fill(4));
    idle(3);
    check("basic_hold", data_out, fill(4));

    b = '0; b[31:0] = 32'hFFFF_FFFF; b[63:32] = 2; drive(1, 0, b);
    b = '0; b[31:0] = 1;             b[63:32] = 2; drive(1, 0, b);
    b = '0;                          b[63:32] = 2; drive(1, 0, b);
    drive(1, 0, b);
    idle(1);
    b = '0; b[63:32] = 8;
    check("lane_wrap", data_out, b);

    drive(1, 0, fill(1));
    drive(1, 0, fill(1));
    idle(3);
    drive(1, 0, fill(1));
    drive(1, 0, fill(1));
    check("gap_before_done", data_out, b);
    idle(1);
    check("gap_sum", data_out, fill(4));

    for (int i = 0; i < 4; i++) begin
      drive(1, 0, fill(1));
      drive(1, 1, fill(10));
    end
    check("interleave_s0", data_out, fill(4));
    idle(1);
    check("interleave_s1", data_out, fill(40));
    idle(1);

    drive(1, 0, fill(5));
    drive(1, 0, fill(5));
    idle(1);
    #2 rst_n = 1;
    #1 check("midburst_reset", data_out, '0);
    @(posedge clk);
    #1 rst_n = 0;
    for (int i = 0; i < 3; i++) drive(1, 0, fill(1));
    check("midburst_partial", data_out, '0);
    drive(1, 0, fill(1));
    idle(1);
    check("midburst_sum", data_out, fill(4));
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/stream_top.md
# stream_top

Top-level datapath that folds fixed-length bursts of wide data beats into one result per stream. Each valid input beat carries a stream ID. The block keeps an independent lane-wise running sum for every stream. When a stream has received N_CYCLES beats, the block publishes that stream's sum on a registered output bus. It sits directly behind the stimulus/ingress driver and is the design's top datapath.

## Interface
- DATA_WIDTH, 512, width of data_in/data_out; must be a multiple of LANE_WIDTH
- LANE_WIDTH, 32, width of one arithmetic lane (DATA_WIDTH/LANE_WIDTH lanes, 16 by default)
- N_CYCLES, 4, beats per stream that form one result; must be ≥ 1
- SID_WIDTH, 1, stream ID width (2**SID_WIDTH independent streams)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset; asynchronous, active-high (asserted when 1) despite its name
- data_in  in  DATA_WIDTH  input beat; lane k is bits [k*LANE_WIDTH +: LANE_WIDTH]
- sid_in  in  SID_WIDTH  stream ID of the current beat
- data_valid  in  1  beat qualifier; data_in/sid_in are ignored when 0
- data_out  out  DATA_WIDTH  most recently completed stream sum; registered and held until the next completion

## Operation
- Per stream s: accumulator acc[s] of DATA_WIDTH bits, organised as lanes, and beat counter cnt[s] of width $clog2(N_CYCLES+1).
- Beat accepted when data_valid=1. There is no back-pressure; every valid beat is consumed.
- Non-final beat (cnt[sid_in] < N_CYCLES-1):
  - acc[sid] lane k <= acc lane k + data_in lane k, modulo 2**LANE_WIDTH
  - cnt[sid]++
  - data_out unchanged
- Final beat (cnt[sid_in] == N_CYCLES-1):
  - data_out <= acc[sid] + data_in, lane-wise, modulo 2**LANE_WIDTH
  - acc[sid] <= 0, cnt[sid] <= 0
- Lanes are independent; there is no carry between lanes.
- Streams are fully independent. Beats of different streams may interleave arbitrarily, and only the addressed stream's state changes.
- N_CYCLES=1: every valid beat is passed straight to data_out, registered.
- data_valid=0: no state changes.

## Timing
- Reset (rst_n=1, asynchronous): data_out=0, all acc=0, all cnt=0 immediately. All partial sums are discarded.
- Reset asserted mid-burst: the partial burst is lost, and counting restarts at beat 0 after release.
- Latency: data_out reflects a completed burst on the rising edge that samples its final beat. It is visible one cycle after that beat is presented.
- Throughput: one beat per cycle, sustained, for any mix of streams.
- Back-to-back completions on consecutive cycles (different streams) update data_out on each of those cycles.
- Idle cycles between beats of the same burst are allowed and do not affect the result.

## Structure
- Shared package stream_top_pkg:
  - constants DATA_WIDTH, LANE_WIDTH, N_LANES, SID_WIDTH, N_STREAMS
  - typedef lane_t (logic [LANE_WIDTH-1:0])
  - typedef beat_t (lane_t array [N_LANES])
  - function lane_add(beat_t, beat_t) → beat_t
- One sub-module, stream_accum: a per-stream accumulator and counter with a final-beat flag and a sum output. stream_top instantiates N_STREAMS copies and muxes the completing stream's sum into the data_out register.

## Test plan
- Reset values:
  - Stimulus: rst_n=1 with random inputs.
  - Expected: data_out=0. After release with no valid beats, data_out stays 0.
- Basic burst:
  - Stimulus: sid 0, four beats, every lane=1.
  - Expected: data_out unchanged until the cycle after beat 4, then every lane=4. It holds 4 while idle.
- Lane wrap:
  - Stimulus: sid 0, beats with lane0 = 0xFFFFFFFF, 1, 0, 0 and lane1 = 2, 2, 2, 2.
  - Expected: lane0=0x00000000, lane1=8, with no carry into lane1.
- Interleave:
  - Stimulus: alternating sid 0 (lanes=1) and sid 1 (lanes=10), four beats each, back-to-back.
  - Expected: data_out lanes=4, then on the next cycle lanes=40.
- Gaps:
  - Stimulus: the basic burst with 3 idle cycles between beats 2 and 3.
  - Expected: the same result (lanes=4), one cycle after beat 4.
- Reset mid-burst:
  - Stimulus: sid 0, 2 beats of lanes=5; reset pulse; then 4 beats of lanes=1.
  - Expected: data_out=0 after reset, then lanes=4 with no trace of the 5s.
